// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for up to 8 requesters.
// A grant is held until the consumer acks it or the requester withdraws.
// On release the priority pointer moves just past the released requester.
// The next winner is granted on the same edge, so back-to-back grants
// have no idle bubble between them.
module rr_arbiter8 #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {StIdle, StBusy} state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   gidx_q;
    logic [N-1:0]    grant_q;
    logic            grant_valid_q;

    logic            release_now;
    logic [PW-1:0]   nxt_ptr;
    logic [PW-1:0]   start;
    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic [N-1:0]    pick_onehot;

    // Release condition and the pointer value a release would install
    always_comb begin
        release_now = (state_q == StBusy) && (ack || !req[gidx_q]);
        if (gidx_q == PW'(N - 1)) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = gidx_q + PW'(1);
        end
    end

    // A release arbitrates from the updated pointer; idle arbitrates from ptr_q.
    // The released requester is searched last, so it only wins when alone.
    always_comb begin
        start = (state_q == StBusy) ? nxt_ptr : ptr_q;
    end

    // Circular first-set search starting at 'start'
    always_comb begin
        int unsigned pos;
        pick_found = 1'b0;
        pick_idx   = '0;
        pos        = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(start) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!pick_found && req[PW'(pos)]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(pos);
            end
        end
    end

    // One-hot form of the selected winner
    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    // Arbitration FSM with registered grant outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            gidx_q        <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // ack is ignored here and never moves the pointer
                    if (pick_found) begin
                        state_q       <= StBusy;
                        gidx_q        <= pick_idx;
                        grant_q       <= pick_onehot;
                        grant_valid_q <= 1'b1;
                    end
                end
                StBusy: begin
                    if (release_now) begin
                        ptr_q <= nxt_ptr;
                        if (pick_found) begin
                            gidx_q        <= pick_idx;
                            grant_q       <= pick_onehot;
                            grant_valid_q <= 1'b1;
                        end else begin
                            state_q       <= StIdle;
                            grant_q       <= '0;
                            grant_valid_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios followed by
// randomized traffic compared against a behavioural round-robin model.
module tb_rr_arbiter8;

    localparam int NREQ = 8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic [7:0] grant;
    logic       grant_valid;

    int n_cmp;
    int n_err;

    // Reference model state: who holds the grant and where priority starts
    bit m_busy;
    int m_owner;
    int m_ptr;

    rr_arbiter8 #(.N(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int find_winner(input int from, input logic [7:0] r);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (from + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_grant();
        logic [7:0] g;
        g = '0;
        if (m_busy) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_edge(input logic r, input logic [7:0] q, input logic a);
        int w;
        if (r) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            w = find_winner(m_ptr, q);
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
            end
        end else if (a || !q[m_owner]) begin
            m_ptr = (m_owner + 1) % NREQ;
            w     = find_winner(m_ptr, q);
            if (w >= 0) m_owner = w;
            else        m_busy  = 0;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one edge, then compare against the model
    task automatic step(input logic r, input logic [7:0] q, input logic a);
        logic [7:0] eg;
        rst = r;
        req = q;
        ack = a;
        @(posedge clk);
        model_edge(r, q, a);
        #1;
        eg = model_grant();
        check("model_grant", grant, eg);
        check("model_valid", {7'b0, grant_valid}, {7'b0, m_busy});
        check("onehot0", {7'b0, $onehot0(grant)}, 8'h01);
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_busy = 0;
        m_owner = 0;
        m_ptr = 0;
        rst = 1'b1;
        req = '0;
        ack = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b1, 8'h00, 1'b0);
        check("reset_grant", grant, 8'h00);
        check("reset_valid", {7'b0, grant_valid}, 8'h00);

        // Single request, ack releases, pointer moves to 1
        step(1'b0, 8'h01, 1'b0);
        check("single_grant", grant, 8'h01);
        check("single_valid", {7'b0, grant_valid}, 8'h01);
        step(1'b0, 8'h00, 1'b1);
        check("single_release", grant, 8'h00);
        check("single_rel_valid", {7'b0, grant_valid}, 8'h00);
        step(1'b0, 8'h03, 1'b0);
        check("ptr_is_1", grant, 8'h02);
        step(1'b0, 8'h00, 1'b1);

        // All requesting, ack every cycle: rotating grants with wrap, no bubble
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        check("rot_first", grant, 8'h01);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] e;
            e = 8'h01 << ((k + 1) % 8);
            step(1'b0, 8'hFF, 1'b1);
            check("rot_seq", grant, e);
            check("rot_valid", {7'b0, grant_valid}, 8'h01);
        end
        step(1'b0, 8'h00, 1'b1);

        // Circular search from pointer 6
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h10, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h21, 1'b0);
        check("ptr5_grant", grant, 8'h20);
        step(1'b0, 8'h21, 1'b1);
        check("wrap_search", grant, 8'h01);
        step(1'b0, 8'h00, 1'b1);

        // Hold while other requests change; withdrawal hands over at once
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h04, 1'b0);
        check("hold_initial", grant, 8'h04);
        step(1'b0, 8'h0C, 1'b0);
        check("hold_steady", grant, 8'h04);
        step(1'b0, 8'h08, 1'b0);
        check("withdraw_handover", grant, 8'h08);
        step(1'b0, 8'h00, 1'b1);

        // Reset while busy drops grant; next arbitration starts from 0
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h40, 1'b0);
        check("pre_rst_grant", grant, 8'h40);
        step(1'b1, 8'h40, 1'b0);
        check("rst_busy_grant", grant, 8'h00);
        check("rst_busy_valid", {7'b0, grant_valid}, 8'h00);
        step(1'b0, 8'hC0, 1'b0);
        check("post_rst_grant", grant, 8'h40);
        step(1'b0, 8'h00, 1'b1);

        // ack while idle changes nothing; pointer still 7 afterwards
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 8'h00, 1'(k % 2));
            check("idle_ack", grant, 8'h00);
        end
        step(1'b0, 8'h81, 1'b0);
        check("idle_ack_ptr", grant, 8'h80);
        step(1'b0, 8'h00, 1'b1);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] q;
            logic       a;
            logic       r;
            q = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 7) == 0) q = 8'h00;
            a = 1'($urandom_range(0, 2) == 0);
            r = 1'($urandom_range(0, 99) == 0);
            step(r, q, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
